// File: rtl/reg_scoreboard_pkg.sv
// Shared defaults and helpers for the multi-writer register scoreboard.
package reg_scoreboard_pkg;

  localparam int CNT_W_DEF    = 2;
  localparam int NUM_REGS_DEF = 32;

  function automatic int ridx_w(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

  typedef logic [CNT_W_DEF-1:0] cnt_t;

endpackage

// File: rtl/sb_cnt_cell.sv
// One saturating per-register counter: post-decrement bypass view, increment, flush, underflow flag.
// Next-state in one cycle; o_post is combinational; no backpressure (caller prevents overflow).
module sb_cnt_cell #(
  parameter int CNT_W = 2,
  parameter int INC_W = 2,
  parameter int DEC_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_flush,
  input  logic [INC_W-1:0] i_inc,
  input  logic [DEC_W-1:0] i_dec,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_post,
  output logic             o_uf
);

  localparam int SW = CNT_W + INC_W + DEC_W;
  localparam logic [SW-1:0] W_MAX = SW'((1 << CNT_W) - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [SW-1:0]    w_cur;
  logic [SW-1:0]    w_dec;
  logic [SW-1:0]    w_post;
  logic [SW-1:0]    w_sum;
  logic [CNT_W-1:0] w_nxt;
  logic             w_uf;

  always_comb begin
    w_cur  = SW'(r_cnt);
    w_dec  = SW'(i_dec);
    w_uf   = (w_dec > w_cur);
    w_post = w_uf ? '0 : (w_cur - w_dec);
    w_sum  = w_post + SW'(i_inc);
    // Saturate rather than wrap if an illegal over-issue slips through.
    w_nxt  = (w_sum > W_MAX) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_flush) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= w_nxt;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_post = w_post[CNT_W-1:0];
  assign o_uf   = w_uf & ~i_flush;

endmodule

// File: rtl/reg_scoreboard_multi.sv
// N-wide issue scoreboard with per-register writer/load counters and intra-bundle hazard chaining.
// Hazards are combinational off registered state plus same-cycle writeback; cnt_full is the only mandatory stall.
module reg_scoreboard_multi
  import reg_scoreboard_pkg::*;
#(
  parameter  int NUM_ISSUE = 2,
  parameter  int NUM_WB    = 2,
  parameter  int NUM_REGS  = NUM_REGS_DEF,
  parameter  int CNT_W     = CNT_W_DEF,
  localparam int RIDX_W    = ridx_w(NUM_REGS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        flush,
  input  logic [NUM_ISSUE-1:0]        req_valid,
  input  logic [NUM_ISSUE-1:0]        issue,
  input  logic [NUM_ISSUE-1:0]        reg_write,
  input  logic [NUM_ISSUE-1:0]        is_load,
  input  logic [NUM_ISSUE*RIDX_W-1:0] rd,
  input  logic [NUM_ISSUE*RIDX_W-1:0] rs1,
  input  logic [NUM_ISSUE*RIDX_W-1:0] rs2,
  input  logic [NUM_ISSUE-1:0]        use_rs1,
  input  logic [NUM_ISSUE-1:0]        use_rs2,
  input  logic [NUM_WB-1:0]           wb_we,
  input  logic [NUM_WB*RIDX_W-1:0]    wb_rd,
  input  logic [NUM_WB-1:0]           wb_is_load,
  output logic [NUM_ISSUE-1:0]        raw_hazard,
  output logic [NUM_ISSUE-1:0]        load_use,
  output logic [NUM_ISSUE-1:0]        waw_hazard,
  output logic [NUM_ISSUE-1:0]        cnt_full,
  output logic [NUM_REGS-1:0]         busy_vec,
  output logic [NUM_REGS-1:0]         load_pending_vec,
  output logic                        underflow_err
);

  localparam int INC_W = $clog2(NUM_ISSUE + 1);
  localparam int DEC_W = $clog2(NUM_WB + 1);
  localparam int VW    = CNT_W + INC_W;
  localparam logic [VW-1:0] W_MAX = VW'((1 << CNT_W) - 1);

  logic [RIDX_W-1:0] w_rd    [NUM_ISSUE];
  logic [RIDX_W-1:0] w_src   [NUM_ISSUE][3];
  logic [RIDX_W-1:0] w_wb_rd [NUM_WB];

  logic [INC_W-1:0]  w_winc  [NUM_REGS];
  logic [INC_W-1:0]  w_linc  [NUM_REGS];
  logic [DEC_W-1:0]  w_wdec  [NUM_REGS];
  logic [DEC_W-1:0]  w_ldec  [NUM_REGS];

  logic [NUM_REGS-1:0][CNT_W-1:0] w_wcnt;
  logic [NUM_REGS-1:0][CNT_W-1:0] w_wv;
  logic [NUM_REGS-1:0][CNT_W-1:0] w_lcnt;
  logic [NUM_REGS-1:0][CNT_W-1:0] w_lv;
  logic [NUM_REGS-1:0]            w_wuf;
  logic [NUM_REGS-1:0]            w_luf;

  logic [VW-1:0]     w_vw    [NUM_ISSUE][3];
  logic [VW-1:0]     w_vl    [NUM_ISSUE][3];

  logic              r_underflow_err;

  always_comb begin
    for (int k = 0; k < NUM_ISSUE; k++) begin
      w_rd[k]     = rd [k*RIDX_W +: RIDX_W];
      w_src[k][0] = rs1[k*RIDX_W +: RIDX_W];
      w_src[k][1] = rs2[k*RIDX_W +: RIDX_W];
      w_src[k][2] = rd [k*RIDX_W +: RIDX_W];
    end
    for (int p = 0; p < NUM_WB; p++) begin
      w_wb_rd[p] = wb_rd[p*RIDX_W +: RIDX_W];
    end
  end

  // Per-register hit counts from issuing slots and writeback ports.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      w_winc[r] = '0;
      w_linc[r] = '0;
      w_wdec[r] = '0;
      w_ldec[r] = '0;
    end
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int k = 0; k < NUM_ISSUE; k++) begin
        if (issue[k] && reg_write[k] && (w_rd[k] == RIDX_W'(r))) begin
          w_winc[r] = w_winc[r] + INC_W'(1);
          if (is_load[k]) w_linc[r] = w_linc[r] + INC_W'(1);
        end
      end
      for (int p = 0; p < NUM_WB; p++) begin
        if (wb_we[p] && (w_wb_rd[p] == RIDX_W'(r))) begin
          w_wdec[r] = w_wdec[r] + DEC_W'(1);
          if (wb_is_load[p]) w_ldec[r] = w_ldec[r] + DEC_W'(1);
        end
      end
    end
  end

  assign w_wcnt[0] = '0;
  assign w_wv[0]   = '0;
  assign w_lcnt[0] = '0;
  assign w_lv[0]   = '0;
  assign w_wuf[0]  = 1'b0;
  assign w_luf[0]  = 1'b0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    sb_cnt_cell #(.CNT_W(CNT_W), .INC_W(INC_W), .DEC_W(DEC_W)) u_wcnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush),
      .i_inc   (w_winc[g]),
      .i_dec   (w_wdec[g]),
      .o_cnt   (w_wcnt[g]),
      .o_post  (w_wv[g]),
      .o_uf    (w_wuf[g])
    );
    sb_cnt_cell #(.CNT_W(CNT_W), .INC_W(INC_W), .DEC_W(DEC_W)) u_lcnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (flush),
      .i_inc   (w_linc[g]),
      .i_dec   (w_ldec[g]),
      .o_cnt   (w_lcnt[g]),
      .o_post  (w_lv[g]),
      .o_uf    (w_luf[g])
    );
  end

  // Slot view: post-writeback counters plus older requesting writers in the bundle.
  always_comb begin
    raw_hazard = '0;
    load_use   = '0;
    waw_hazard = '0;
    cnt_full   = '0;
    for (int k = 0; k < NUM_ISSUE; k++) begin
      for (int s = 0; s < 3; s++) begin
        w_vw[k][s] = VW'(w_wv[w_src[k][s]]);
        w_vl[k][s] = VW'(w_lv[w_src[k][s]]);
        for (int j = 0; j < k; j++) begin
          if (req_valid[j] && reg_write[j] && (w_rd[j] == w_src[k][s]) &&
              (w_src[k][s] != '0)) begin
            w_vw[k][s] = w_vw[k][s] + VW'(1);
            if (is_load[j]) w_vl[k][s] = w_vl[k][s] + VW'(1);
          end
        end
      end
      if (req_valid[k]) begin
        raw_hazard[k] = (use_rs1[k] && (w_vw[k][0] != '0)) ||
                        (use_rs2[k] && (w_vw[k][1] != '0));
        load_use[k]   = (use_rs1[k] && (w_vl[k][0] != '0)) ||
                        (use_rs2[k] && (w_vl[k][1] != '0));
        waw_hazard[k] = reg_write[k] && (w_rd[k] != '0) && (w_vw[k][2] != '0);
        cnt_full[k]   = reg_write[k] && (w_rd[k] != '0) &&
                        ((w_vw[k][2] == W_MAX) || (is_load[k] && (w_vl[k][2] == W_MAX)));
      end
    end
  end

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      busy_vec[r]         = |w_wcnt[r];
      load_pending_vec[r] = |w_lcnt[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_underflow_err <= 1'b0;
    end else if ((|w_wuf) || (|w_luf)) begin
      r_underflow_err <= 1'b1;
    end
  end

  assign underflow_err = r_underflow_err;

endmodule

// File: tb/tb_reg_scoreboard_multi.sv
// Scoreboard bench: counter-array reference model, expectations queued by the driver, checked by a monitor.
module tb_reg_scoreboard_multi;
  import reg_scoreboard_pkg::*;

  localparam int NI   = 2;
  localparam int NW   = 2;
  localparam int NR   = 32;
  localparam int RW   = 5;
  localparam int MAXC = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic [NI-1:0] req_valid, issue, reg_write, is_load, use_rs1, use_rs2;
  logic [NI*RW-1:0] rd, rs1, rs2;
  logic [NW-1:0] wb_we, wb_is_load;
  logic [NW*RW-1:0] wb_rd;
  logic [NI-1:0] raw_hazard, load_use, waw_hazard, cnt_full;
  logic [NR-1:0] busy_vec, load_pending_vec;
  logic underflow_err;

  reg_scoreboard_multi #(.NUM_ISSUE(NI), .NUM_WB(NW), .NUM_REGS(NR), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .req_valid(req_valid), .issue(issue),
    .reg_write(reg_write), .is_load(is_load), .rd(rd), .rs1(rs1), .rs2(rs2),
    .use_rs1(use_rs1), .use_rs2(use_rs2), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_is_load(wb_is_load), .raw_hazard(raw_hazard), .load_use(load_use),
    .waw_hazard(waw_hazard), .cnt_full(cnt_full), .busy_vec(busy_vec),
    .load_pending_vec(load_pending_vec), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NI-1:0] raw, lu, waw, full;
    logic [NR-1:0] busy, lpend;
    logic          uf;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: outstanding writer/load counts per register.
  int wc[NR], lc[NR], pwc[NR], plc[NR];
  bit m_uf, p_uf;
  cnt_t max_cnt;

  // Stimulus for the current cycle.
  logic [NI-1:0] s_rv, s_rw, s_il, s_u1, s_u2, s_iss;
  int            s_rd[NI], s_rs1[NI], s_rs2[NI], s_wbrd[NW];
  logic [NW-1:0] s_we, s_wil;
  bit            s_fl, s_auto;

  task automatic clr();
    s_rv = '0; s_rw = '0; s_il = '0; s_u1 = '0; s_u2 = '0; s_iss = '0;
    s_we = '0; s_wil = '0; s_fl = 1'b0; s_auto = 1'b0;
    for (int k = 0; k < NI; k++) begin s_rd[k] = 0; s_rs1[k] = 0; s_rs2[k] = 0; end
    for (int p = 0; p < NW; p++) s_wbrd[p] = 0;
  endtask

  task automatic drive();
    flush = s_fl; req_valid = s_rv; issue = s_iss; reg_write = s_rw; is_load = s_il;
    use_rs1 = s_u1; use_rs2 = s_u2; wb_we = s_we; wb_is_load = s_wil;
    for (int k = 0; k < NI; k++) begin
      rd[k*RW +: RW] = RW'(s_rd[k]); rs1[k*RW +: RW] = RW'(s_rs1[k]); rs2[k*RW +: RW] = RW'(s_rs2[k]);
    end
    for (int p = 0; p < NW; p++) wb_rd[p*RW +: RW] = RW'(s_wbrd[p]);
  endtask

  // Writers visible to slot k on register r (load-only view when ld is set).
  function automatic int view(int k, int r, bit ld);
    int v;
    if (r == 0) return 0;
    v = ld ? plc[r] : pwc[r];
    for (int j = 0; j < k; j++)
      if (s_rv[j] && s_rw[j] && s_rd[j] == r && (!ld || s_il[j])) v++;
    return v;
  endfunction

  task automatic cyc();
    exp_t e;
    bit   ok;
    pwc = wc; plc = lc; p_uf = 0;
    for (int p = 0; p < NW; p++)
      if (s_we[p] && s_wbrd[p] != 0) begin
        pwc[s_wbrd[p]]--;
        if (s_wil[p]) plc[s_wbrd[p]]--;
      end
    for (int r = 0; r < NR; r++) begin
      if (pwc[r] < 0) begin pwc[r] = 0; p_uf = 1; end
      if (plc[r] < 0) begin plc[r] = 0; p_uf = 1; end
    end
    for (int r = 0; r < NR; r++) begin e.busy[r] = (wc[r] != 0); e.lpend[r] = (lc[r] != 0); end
    e.uf = m_uf;
    e.raw = '0; e.lu = '0; e.waw = '0; e.full = '0;
    for (int k = 0; k < NI; k++) if (s_rv[k]) begin
      e.raw[k]  = (s_u1[k] && view(k, s_rs1[k], 0) != 0) || (s_u2[k] && view(k, s_rs2[k], 0) != 0);
      e.lu[k]   = (s_u1[k] && view(k, s_rs1[k], 1) != 0) || (s_u2[k] && view(k, s_rs2[k], 1) != 0);
      e.waw[k]  = s_rw[k] && s_rd[k] != 0 && view(k, s_rd[k], 0) != 0;
      e.full[k] = s_rw[k] && s_rd[k] != 0 &&
                  (view(k, s_rd[k], 0) == MAXC || (s_il[k] && view(k, s_rd[k], 1) == MAXC));
    end
    exp_q.push_back(e);
    if (s_auto) begin
      ok = 1;
      for (int k = 0; k < NI; k++) begin
        s_iss[k] = ok && s_rv[k] && !e.raw[k] && !e.full[k] && ($urandom % 8 != 0);
        ok = s_iss[k];
      end
    end
    drive();
    @(posedge clk);
    for (int k = 0; k < NI; k++)
      if (s_iss[k] && s_rw[k] && s_rd[k] != 0) begin
        if (pwc[s_rd[k]] < MAXC) pwc[s_rd[k]]++;
        if (s_il[k] && plc[s_rd[k]] < MAXC) plc[s_rd[k]]++;
      end
    if (s_fl) begin
      for (int r = 0; r < NR; r++) begin wc[r] = 0; lc[r] = 0; end
    end else begin
      wc = pwc; lc = plc; m_uf = m_uf | p_uf;
    end
    #1;
  endtask

  task automatic reset_seq();
    rst_n = 1'b0;
    clr();
    for (int r = 0; r < NR; r++) begin wc[r] = 0; lc[r] = 0; end
    m_uf = 0;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic rnd();
    int av[NR], lav[NR];
    int cand[$];
    int r;
    clr();
    for (int k = 0; k < NI; k++) begin
      s_rv[k] = ($urandom % 4) != 0;
      s_rw[k] = ($urandom % 10) < 7;
      s_il[k] = ($urandom % 10) < 4;
      s_u1[k] = $urandom % 2;
      s_u2[k] = $urandom % 2;
      s_rd[k] = $urandom_range(0, 7);
      s_rs1[k] = $urandom_range(0, 7);
      s_rs2[k] = $urandom_range(0, 7);
    end
    av = wc; lav = lc;
    for (int p = 0; p < NW; p++) begin
      cand.delete();
      for (int i = 1; i < 8; i++) if (av[i] > 0) cand.push_back(i);
      if (($urandom % 100) < 55 && cand.size() > 0) begin
        r = cand[$urandom_range(0, cand.size() - 1)];
        s_we[p] = 1'b1; s_wbrd[p] = r;
        if (lav[r] > 0 && (lav[r] == av[r] || ($urandom % 2) == 1)) begin
          s_wil[p] = 1'b1; lav[r]--;
        end
        av[r]--;
      end else if (($urandom % 20) == 0) begin
        s_we[p] = 1'b1; s_wbrd[p] = 0;
      end
    end
    s_fl = ($urandom % 50) == 0;
    s_auto = 1'b1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("raw_hazard", 64'(raw_hazard), 64'(e.raw));
      chk("load_use", 64'(load_use), 64'(e.lu));
      chk("waw_hazard", 64'(waw_hazard), 64'(e.waw));
      chk("cnt_full", 64'(cnt_full), 64'(e.full));
      chk("busy_vec", 64'(busy_vec), 64'(e.busy));
      chk("load_pending_vec", 64'(load_pending_vec), 64'(e.lpend));
      chk("underflow_err", 64'(underflow_err), 64'(e.uf));
      chk("issue_while_full", 64'(issue & cnt_full), 64'd0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    max_cnt = '1;
    rst_n = 1'b0;
    clr();
    drive();
    @(posedge clk); #1;
    reset_seq();

    // ALU write to x5, then dependent read in the next cycle.
    clr(); s_rv[0] = 1; s_rw[0] = 1; s_rd[0] = 5; s_iss[0] = 1; cyc();
    clr(); s_rv[1] = 1; s_u1[1] = 1; s_rs1[1] = 5; cyc();
    clr(); s_we[0] = 1; s_wbrd[0] = 5; cyc();

    // Load to x7 completes in the same cycle a consumer reads it.
    clr(); s_rv[0] = 1; s_rw[0] = 1; s_il[0] = 1; s_rd[0] = 7; s_iss[0] = 1; cyc();
    clr(); s_we[0] = 1; s_wbrd[0] = 7; s_wil[0] = 1; s_rv[0] = 1; s_u2[0] = 1; s_rs2[0] = 7; cyc();
    clr(); cyc();

    // Intra-bundle load-use chaining.
    clr(); s_rv = 2'b11; s_rw[0] = 1; s_il[0] = 1; s_rd[0] = 3; s_u1[1] = 1; s_rs1[1] = 3; cyc();

    // Two writers to x9, drained one at a time.
    for (int i = 0; i < 2; i++) begin
      clr(); s_rv[0] = 1; s_rw[0] = 1; s_rd[0] = 9; s_iss[0] = 1; cyc();
    end
    for (int i = 0; i < 3; i++) begin
      clr(); if (i < 2) begin s_we[0] = 1; s_wbrd[0] = 9; end cyc();
    end

    // Fill x4 to the counter maximum, then a fourth candidate must see cnt_full.
    for (int i = 0; i < int'(max_cnt); i++) begin
      clr(); s_rv[0] = 1; s_rw[0] = 1; s_rd[0] = 4; s_iss[0] = 1; cyc();
    end
    clr(); s_rv[0] = 1; s_rw[0] = 1; s_rd[0] = 4; cyc();
    clr(); s_we = 2'b11; s_wbrd[0] = 4; s_wbrd[1] = 4; cyc();
    clr(); s_rv[1] = 1; s_u2[1] = 1; s_rs2[1] = 4; s_we[0] = 1; s_wbrd[0] = 4; cyc();
    clr(); cyc();

    // Flush beats a same-cycle issue; a stale writeback then trips the sticky error.
    clr(); s_rv[0] = 1; s_rw[0] = 1; s_rd[0] = 2; s_iss[0] = 1; cyc();
    clr(); s_fl = 1; s_rv[0] = 1; s_rw[0] = 1; s_rd[0] = 6; s_iss[0] = 1; cyc();
    clr(); s_we[1] = 1; s_wbrd[1] = 2; cyc();
    clr(); cyc();
    clr(); cyc();
    reset_seq();
    clr(); cyc();

    for (int n = 0; n < 2000; n++) begin
      rnd();
      cyc();
    end
    clr(); cyc();

    for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
